// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with 31x32 register file and ID/EX output register.
// Ports: clk, rst_n (async, active-low); pc_i, ir_i from fetch; stall_i, flush_i
// pipeline control; wb_en_i, wb_rd_i, wb_data_i register-file write port;
// valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rd_o, alu_op_o, op_class_o,
// illegal_o registered ID/EX bundle.
// Parameter BUBBLE_ON_ZERO: all-zero ir_i decodes as a bubble, not illegal.
// Macro DECODE_WB_BYPASS_EN: same-cycle write-back data forwarded to reads.
module decode_stage #(
    parameter bit BUBBLE_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    input  logic [31:0] ir_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        wb_en_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rd_o,
    output logic [3:0]  alu_op_o,
    output logic [2:0]  op_class_o,
    output logic        illegal_o
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [2:0] CLS_ALU   = 3'd0;
    localparam logic [2:0] CLS_LOAD  = 3'd1;
    localparam logic [2:0] CLS_STORE = 3'd2;
    localparam logic [2:0] CLS_BR    = 3'd3;
    localparam logic [2:0] CLS_JAL   = 3'd4;
    localparam logic [2:0] CLS_JALR  = 3'd5;
    localparam logic [2:0] CLS_LUI   = 3'd6;
    localparam logic [2:0] CLS_AUIPC = 3'd7;

    logic [31:0] rf [1:31];

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic        is_bubble;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    logic        d_valid;
    logic        d_illegal;
    logic [4:0]  d_rd;
    logic [2:0]  d_class;
    logic [3:0]  d_alu;
    logic [31:0] d_imm;

    assign opcode  = ir_i[6:0];
    assign funct3  = ir_i[14:12];
    assign rs1_idx = ir_i[19:15];
    assign rs2_idx = ir_i[24:20];

    assign is_bubble = BUBBLE_ON_ZERO && (ir_i == 32'b0);

    assign imm_i = {{20{ir_i[31]}}, ir_i[31:20]};
    assign imm_s = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
    assign imm_b = {{20{ir_i[31]}}, ir_i[7], ir_i[30:25],
                    ir_i[11:8], 1'b0};
    assign imm_u = {ir_i[31:12], 12'b0};
    assign imm_j = {{12{ir_i[31]}}, ir_i[19:12], ir_i[20],
                    ir_i[30:21], 1'b0};

    // Register file writes are never gated by stall/flush: write-back
    // belongs to an older instruction that has already committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                rf[i] <= 32'b0;
            end
        end else if (wb_en_i && (wb_rd_i != 5'd0)) begin
            rf[wb_rd_i] <= wb_data_i;
        end
    end

    always_comb begin
        rs1_val = (rs1_idx == 5'd0) ? 32'b0 : rf[rs1_idx];
        rs2_val = (rs2_idx == 5'd0) ? 32'b0 : rf[rs2_idx];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs1_idx)) begin
            rs1_val = wb_data_i;
        end
        if (wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs2_idx)) begin
            rs2_val = wb_data_i;
        end
`else
        // Same-cycle reads see the pre-write value; hazard logic
        // upstream is responsible for the write-back gap.
`endif
    end

    always_comb begin
        d_valid   = 1'b1;
        d_illegal = 1'b0;
        d_rd      = ir_i[11:7];
        d_class   = CLS_ALU;
        d_alu     = 4'b0000;
        d_imm     = 32'b0;
        unique case (1'b1)
            is_bubble: begin
                d_valid = 1'b0;
                d_rd    = 5'd0;
            end
            opcode == OPC_OP: begin
                d_alu = {ir_i[30], funct3};
            end
            opcode == OPC_OPIMM: begin
                d_imm = imm_i;
                // ir[30] only selects SRAI vs SRLI among immediates.
                d_alu = (funct3 == 3'b101) ? {ir_i[30], funct3}
                                           : {1'b0, funct3};
            end
            opcode == OPC_LOAD: begin
                d_class = CLS_LOAD;
                d_imm   = imm_i;
            end
            opcode == OPC_STORE: begin
                d_class = CLS_STORE;
                d_imm   = imm_s;
                d_rd    = 5'd0;
            end
            opcode == OPC_BR: begin
                d_class = CLS_BR;
                d_imm   = imm_b;
                d_rd    = 5'd0;
                d_alu   = {1'b0, funct3};
            end
            opcode == OPC_JAL: begin
                d_class = CLS_JAL;
                d_imm   = imm_j;
            end
            opcode == OPC_JALR: begin
                d_class = CLS_JALR;
                d_imm   = imm_i;
            end
            opcode == OPC_LUI: begin
                d_class = CLS_LUI;
                d_imm   = imm_u;
            end
            opcode == OPC_AUIPC: begin
                d_class = CLS_AUIPC;
                d_imm   = imm_u;
            end
            default: begin
                d_illegal = 1'b1;
                d_rd      = 5'd0;
            end
        endcase
    end

    // Flush wins over stall. Data fields are don't-care under flush
    // and simply follow the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o    <= 1'b0;
            pc_o       <= 32'b0;
            rs1_data_o <= 32'b0;
            rs2_data_o <= 32'b0;
            imm_o      <= 32'b0;
            rd_o       <= 5'd0;
            alu_op_o   <= 4'b0;
            op_class_o <= 3'd0;
            illegal_o  <= 1'b0;
        end else if (flush_i) begin
            valid_o    <= 1'b0;
            pc_o       <= pc_i;
            rs1_data_o <= rs1_val;
            rs2_data_o <= rs2_val;
            imm_o      <= d_imm;
            rd_o       <= 5'd0;
            alu_op_o   <= 4'b0;
            op_class_o <= 3'd0;
            illegal_o  <= 1'b0;
        end else if (!stall_i) begin
            valid_o    <= d_valid;
            pc_o       <= pc_i;
            rs1_data_o <= rs1_val;
            rs2_data_o <= rs2_val;
            imm_o      <= d_imm;
            rd_o       <= d_rd;
            alu_op_o   <= d_alu;
            op_class_o <= d_class;
            illegal_o  <= d_illegal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: vector table, directed corner sequences and random
// stimulus for decode_stage, checked against a behavioural model.
module tb_decode_stage;

    localparam bit BUBBLE = 1'b1;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_i;
    logic [31:0] ir_i;
    logic        stall_i;
    logic        flush_i;
    logic        wb_en_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic [31:0] imm_o;
    logic [4:0]  rd_o;
    logic [3:0]  alu_op_o;
    logic [2:0]  op_class_o;
    logic        illegal_o;

    decode_stage #(.BUBBLE_ON_ZERO(BUBBLE)) dut (
        .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .ir_i(ir_i),
        .stall_i(stall_i), .flush_i(flush_i), .wb_en_i(wb_en_i),
        .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .valid_o(valid_o),
        .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .imm_o(imm_o), .rd_o(rd_o), .alu_op_o(alu_op_o),
        .op_class_o(op_class_o), .illegal_o(illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Opcode -> class table; class 2/3 instructions write no register.
    localparam logic [6:0] OPC [9] = '{7'h33, 7'h13, 7'h03, 7'h23,
                                       7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    localparam int CLS [9] = '{0, 0, 1, 2, 3, 4, 5, 6, 7};

    logic [31:0] rf_m [32];

    logic        e_valid;
    logic        e_ill;
    logic [4:0]  e_rd;
    logic [2:0]  e_cls;
    logic [3:0]  e_alu;
    logic [31:0] e_pc;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic [31:0] e_imm;
    logic        e_data_known;
    logic        e_imm_known;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] imm;
        logic        chk_imm;
        logic [4:0]  rd;
        logic [2:0]  cls;
        logic [3:0]  alu;
        logic        ill;
        logic        valid;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [4:0] r);
        if (r == 5'd0) return 32'b0;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en_i && wb_rd_i == r) return wb_data_i;
`endif
        return rf_m[r];
    endfunction

    task automatic ref_decode(input logic [31:0] ir, output logic v,
                              output logic il, output logic [4:0] rd,
                              output logic [2:0] cls, output logic [3:0] alu,
                              output logic [31:0] imm, output logic imm_ok);
        int k;
        int top;
        int hi;
        logic [2:0] f3;
        f3 = ir[14:12];
        k = -1;
        for (int i = 0; i < 9; i++) if (OPC[i] == ir[6:0]) k = i;
        v = 1'b1; il = 1'b0; rd = 5'd0; cls = 3'd0; alu = 4'd0;
        imm = 32'b0; imm_ok = 1'b1;
        top = $signed(ir) >>> 31;
        if (BUBBLE && ir == 32'b0) begin
            v = 1'b0;
        end else if (k < 0) begin
            il = 1'b1;
            imm_ok = 1'b0;
        end else begin
            cls = 3'(CLS[k]);
            if (CLS[k] != 2 && CLS[k] != 3) rd = ir[11:7];
            if (k == 0 || (k == 1 && f3 == 3'd5)) alu = {ir[30], f3};
            else if (k == 1 || k == 4) alu = {1'b0, f3};
            case (CLS[k])
                2: begin
                    hi = $signed(ir) >>> 25;
                    imm = 32'(hi * 32 + int'(ir[11:7]));
                end
                3: imm = 32'(top * 4096 + int'(ir[7]) * 2048
                             + int'(ir[30:25]) * 32 + int'(ir[11:8]) * 2);
                4: imm = 32'(top * 1048576 + int'(ir[19:12]) * 4096
                             + int'(ir[20]) * 2048 + int'(ir[30:21]) * 2);
                6, 7: imm = ir & 32'hFFFF_F000;
                default: begin
                    if (k == 0) imm = 32'b0;
                    else begin
                        hi = $signed(ir) >>> 20;
                        imm = 32'(hi);
                    end
                end
            endcase
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) rf_m[i] = 32'b0;
        e_valid = 0; e_ill = 0; e_rd = 0; e_cls = 0; e_alu = 0;
        e_pc = 0; e_rs1 = 0; e_rs2 = 0; e_imm = 0;
        e_data_known = 1; e_imm_known = 1;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".valid"}, 32'(valid_o), 32'(e_valid));
        chk({tag, ".illegal"}, 32'(illegal_o), 32'(e_ill));
        chk({tag, ".rd"}, 32'(rd_o), 32'(e_rd));
        chk({tag, ".class"}, 32'(op_class_o), 32'(e_cls));
        chk({tag, ".alu"}, 32'(alu_op_o), 32'(e_alu));
        if (e_data_known) begin
            chk({tag, ".pc"}, pc_o, e_pc);
            chk({tag, ".rs1"}, rs1_data_o, e_rs1);
            chk({tag, ".rs2"}, rs2_data_o, e_rs2);
            if (e_imm_known) chk({tag, ".imm"}, imm_o, e_imm);
        end
    endtask

    task automatic cycle(input string tag);
        logic v, il, ok;
        logic [4:0] rd;
        logic [2:0] cls;
        logic [3:0] alu;
        logic [31:0] imm, r1, r2;
        ref_decode(ir_i, v, il, rd, cls, alu, imm, ok);
        r1 = rd_model(ir_i[19:15]);
        r2 = rd_model(ir_i[24:20]);
        if (flush_i) begin
            e_valid = 0; e_ill = 0; e_rd = 0; e_cls = 0; e_alu = 0;
            e_data_known = 0;
        end else if (!stall_i) begin
            e_valid = v; e_ill = il; e_rd = rd; e_cls = cls; e_alu = alu;
            e_pc = pc_i; e_rs1 = r1; e_rs2 = r2; e_imm = imm;
            e_data_known = 1; e_imm_known = ok;
        end
        if (wb_en_i && wb_rd_i != 5'd0) rf_m[wb_rd_i] = wb_data_i;
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"}, 32'(valid_o), 0);
        chk({tag, ".pc"}, pc_o, 0);
        chk({tag, ".rs1"}, rs1_data_o, 0);
        chk({tag, ".rs2"}, rs2_data_o, 0);
        chk({tag, ".imm"}, imm_o, 0);
        chk({tag, ".rd"}, 32'(rd_o), 0);
        chk({tag, ".alu"}, 32'(alu_op_o), 0);
        chk({tag, ".class"}, 32'(op_class_o), 0);
        chk({tag, ".illegal"}, 32'(illegal_o), 0);
    endtask

    initial begin
        logic [31:0] r;
        vecs[0]  = '{32'h00528313, 32'h00000005, 1, 6, 0, 0, 0, 1};
        vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 1, 0, 3, 0, 0, 1};
        vecs[2]  = '{32'hFFFFFFFF, 32'h00000000, 0, 0, 0, 0, 1, 1};
        vecs[3]  = '{32'h00000000, 32'h00000000, 1, 0, 0, 0, 0, 0};
        vecs[4]  = '{32'h002081B3, 32'h00000000, 1, 3, 0, 0, 0, 1};
        vecs[5]  = '{32'h402081B3, 32'h00000000, 1, 3, 0, 8, 0, 1};
        vecs[6]  = '{32'h40335293, 32'h00000403, 1, 5, 0, 13, 0, 1};
        vecs[7]  = '{32'hFFF17093, 32'hFFFFFFFF, 1, 1, 0, 7, 0, 1};
        vecs[8]  = '{32'h00812203, 32'h00000008, 1, 4, 1, 0, 0, 1};
        vecs[9]  = '{32'hFE512C23, 32'hFFFFFFF8, 1, 0, 2, 0, 0, 1};
        vecs[10] = '{32'h010000EF, 32'h00000010, 1, 1, 4, 0, 0, 1};
        vecs[11] = '{32'hFFDFF0EF, 32'hFFFFFFFC, 1, 1, 4, 0, 0, 1};
        vecs[12] = '{32'h00008067, 32'h00000000, 1, 0, 5, 0, 0, 1};
        vecs[13] = '{32'h12345537, 32'h12345000, 1, 10, 6, 0, 0, 1};
        vecs[14] = '{32'h80000117, 32'h80000000, 1, 2, 7, 0, 0, 1};
        vecs[15] = '{32'h00209463, 32'h00000008, 1, 0, 3, 1, 0, 1};
        vecs[16] = '{32'h0000100B, 32'h00000000, 0, 0, 0, 0, 1, 1};

        rst_n = 0; pc_i = 0; ir_i = 0; stall_i = 0; flush_i = 0;
        wb_en_i = 0; wb_rd_i = 0; wb_data_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("in_reset");
        rst_n = 1;
        cycle("reset_release");
        check_zero("first_bubble");

        // x5 = 0xAA, then addi x6,x5,5
        wb_en_i = 1; wb_rd_i = 5; wb_data_i = 32'hAA;
        cycle("wb_x5");
        wb_en_i = 0; ir_i = 32'h00528313; pc_i = 32'h10;
        cycle("addi");
        chk("addi_rs1", rs1_data_o, 32'hAA);
        chk("addi_imm", imm_o, 32'h5);

        foreach (vecs[i]) begin
            ir_i = vecs[i].ir;
            pc_i = 32'h1000 + 32'(i) * 4;
            cycle("vec_model");
            chk($sformatf("vec%0d.valid", i), 32'(valid_o), 32'(vecs[i].valid));
            chk($sformatf("vec%0d.ill", i), 32'(illegal_o), 32'(vecs[i].ill));
            chk($sformatf("vec%0d.rd", i), 32'(rd_o), 32'(vecs[i].rd));
            chk($sformatf("vec%0d.cls", i), 32'(op_class_o), 32'(vecs[i].cls));
            chk($sformatf("vec%0d.alu", i), 32'(alu_op_o), 32'(vecs[i].alu));
            if (vecs[i].chk_imm)
                chk($sformatf("vec%0d.imm", i), imm_o, vecs[i].imm);
        end

        // Same-cycle write-back to x7 while addi x8,x7,0 reads it.
        wb_en_i = 1; wb_rd_i = 7; wb_data_i = 32'h55; ir_i = 0;
        cycle("wb_x7_old");
        wb_data_i = 32'h1234; ir_i = 32'h00038413;
        cycle("bypass");
`ifdef DECODE_WB_BYPASS_EN
        chk("bypass_rs1", rs1_data_o, 32'h1234);
`else
        chk("bypass_rs1", rs1_data_o, 32'h55);
`endif
        wb_en_i = 0;
        cycle("after_wb");
        chk("after_wb_rs1", rs1_data_o, 32'h1234);

        // Write to x0 is dropped.
        wb_en_i = 1; wb_rd_i = 0; wb_data_i = 32'hDEAD; ir_i = 0;
        cycle("wb_x0");
        wb_en_i = 0; ir_i = 32'h00000093;
        cycle("read_x0");
        chk("x0_reads_zero", rs1_data_o, 32'h0);

        // Freeze for 3 cycles while ir_i keeps changing.
        ir_i = 32'h12345537; pc_i = 32'h100;
        cycle("pre_stall");
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            ir_i = 32'h00812203 + 32'(i) * 32'h80;
            pc_i = 32'h200 + 32'(i);
            wb_en_i = 1; wb_rd_i = 5'(10 + i); wb_data_i = 32'(i + 1);
            cycle("stall");
            chk("stall_pc", pc_o, 32'h100);
            chk("stall_imm", imm_o, 32'h12345000);
            chk("stall_rd", 32'(rd_o), 32'd10);
            chk("stall_cls", 32'(op_class_o), 32'd6);
        end
        wb_en_i = 0;
        flush_i = 1;
        cycle("flush_stall");
        chk("flush_valid", 32'(valid_o), 0);
        chk("flush_rd", 32'(rd_o), 0);
        stall_i = 0; flush_i = 0; ir_i = 32'h00058613; // addi x12,x11,0
        cycle("after_flush");
        chk("wb_during_stall", rs1_data_o, 32'h2);

        // Async reset in the middle of a stall+flush.
        ir_i = 32'h12345537; pc_i = 32'h300;
        cycle("pre_reset");
        stall_i = 1; flush_i = 1;
        #2 rst_n = 0;
        #1 check_zero("async_reset");
        @(posedge clk);
        #1 check_zero("held_reset");
        rst_n = 1; stall_i = 0; flush_i = 0;
        model_reset();
        ir_i = 32'h00528313; pc_i = 32'h40;
        cycle("post_reset");
        chk("post_reset_valid", 32'(valid_o), 1);
        chk("post_reset_rd", 32'(rd_o), 6);
        chk("rf_cleared", rs1_data_o, 32'h0);

        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            case ($urandom_range(0, 9))
                0: ir_i = 32'b0;
                1: ir_i = r;
                default: ir_i = {r[31:7], OPC[$urandom_range(0, 8)]};
            endcase
            pc_i = $urandom;
            stall_i = ($urandom_range(0, 4) == 0);
            flush_i = ($urandom_range(0, 7) == 0);
            wb_en_i = $urandom_range(0, 1) == 1;
            wb_rd_i = 5'($urandom_range(0, 31));
            wb_data_i = $urandom;
            if ($urandom_range(0, 3) == 0) ir_i[19:15] = wb_rd_i;
            if ($urandom_range(0, 3) == 0) ir_i[24:20] = wb_rd_i;
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
